// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Holds the FSM state encoding, datapath widths and special-case results.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    CORR = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam int N          = 8;
  localparam int RW         = 10;
  localparam int ITER_COUNT = 8;

  localparam logic [N-1:0] QUO_DIV0 = 8'hFF;
  localparam logic [N-1:0] QUO_OVF  = 8'h80;

  // Unsigned magnitude of a two's-complement operand; -128 maps to 128.
  function automatic logic [N-1:0] mag(input logic [N-1:0] v);
    return v[N-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_addsub.sv
// Combinational add/subtract used by both the iteration and the final
// remainder correction: y = a + b when sub = 0, y = a - b when sub = 1.
module div_addsub
  import div_pkg::*;
(
  input  logic [RW-1:0] a,
  input  logic [RW-1:0] b,
  input  logic          sub,
  output logic [RW-1:0] y
);

  logic [RW-1:0] b_eff;

  genvar gi;
  generate
    for (gi = 0; gi < RW; gi++) begin : g_inv
      assign b_eff[gi] = b[gi] ^ sub;
    end
  endgenerate

  assign y = a + b_eff + {{(RW-1){1'b0}}, sub};

endmodule

// File: rtl/booth_divider.sv
// Signed 8-bit truncating divider: radix-2 non-restoring iterations on
// operand magnitudes, one final remainder correction, then sign fix-up.
module booth_divider
  import div_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [N-1:0] DIVIDEND,
  input  logic [N-1:0] DIVISOR,
  output logic [N-1:0] QUOTIENT,
  output logic [N-1:0] REMAINDER,
  output logic         BUSY,
  output logic         DONE,
  output logic         DIV0,
  output logic         OVF
);

  state_t        state_reg, state_next;
  logic [RW-1:0] r_reg;
  logic [N-1:0]  q_reg;
  logic [N-1:0]  d_reg;
  logic [3:0]    count_reg;
  logic          sign_a_reg, sign_b_reg, ovf_pend_reg;
  logic [N-1:0]  quotient_reg, remainder_reg;
  logic          div0_reg, ovf_reg;

  logic [RW-1:0] r_shift, as_a, as_y, r_fix;
  logic          as_sub;
  logic [N-1:0]  q_step, quo_fin, rem_fin;
  logic          divisor_zero;

  assign divisor_zero = (DIVISOR == '0);

  // One adder serves both states: shifted step in ITER, +D repair in CORR.
  assign r_shift = {r_reg[RW-2:0], q_reg[N-1]};
  assign as_a    = (state_reg == CORR) ? r_reg : r_shift;
  assign as_sub  = (state_reg == CORR) ? 1'b0 : ~r_reg[RW-1];

  div_addsub u_addsub (
    .a   (as_a),
    .b   ({{(RW-N){1'b0}}, d_reg}),
    .sub (as_sub),
    .y   (as_y)
  );

  assign q_step  = {q_reg[N-2:0], ~as_y[RW-1]};
  assign r_fix   = r_reg[RW-1] ? as_y : r_reg;
  assign quo_fin = (sign_a_reg ^ sign_b_reg) ? (~q_reg + 1'b1) : q_reg;
  assign rem_fin = sign_a_reg ? (~r_fix[N-1:0] + 1'b1) : r_fix[N-1:0];

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (START) state_next = divisor_zero ? FIN : ITER;
      ITER: if (count_reg == 4'd1) state_next = CORR;
      CORR: state_next = FIN;
      FIN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state_reg == ITER) || (state_reg == CORR);
    DONE = (state_reg == FIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_reg         <= '0;
      q_reg         <= '0;
      d_reg         <= '0;
      count_reg     <= '0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      ovf_pend_reg  <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      div0_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (START) begin
          sign_a_reg   <= DIVIDEND[N-1];
          sign_b_reg   <= DIVISOR[N-1];
          r_reg        <= '0;
          q_reg        <= mag(DIVIDEND);
          d_reg        <= mag(DIVISOR);
          count_reg    <= 4'(ITER_COUNT);
          ovf_pend_reg <= (DIVIDEND == 8'h80) && (DIVISOR == 8'hFF);
          div0_reg     <= divisor_zero;
          ovf_reg      <= 1'b0;
          if (divisor_zero) begin
            quotient_reg  <= QUO_DIV0;
            remainder_reg <= DIVIDEND;
          end
        end
        ITER: begin
          r_reg     <= as_y;
          q_reg     <= q_step;
          count_reg <= count_reg - 4'd1;
        end
        CORR: begin
          r_reg <= r_fix;
          if (ovf_pend_reg) begin
            quotient_reg  <= QUO_OVF;
            remainder_reg <= '0;
            ovf_reg       <= 1'b1;
          end else begin
            quotient_reg  <= quo_fin;
            remainder_reg <= rem_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign QUOTIENT  = quotient_reg;
  assign REMAINDER = remainder_reg;
  assign DIV0      = div0_reg;
  assign OVF       = ovf_reg;

endmodule

// File: tb/tb_booth_divider.sv
// Scoreboard bench for booth_divider: stimulus pushes expected results,
// a negedge monitor pops and compares on every DONE pulse.
module tb_booth_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend, divisor;
  logic [7:0] quotient, remainder;
  logic       busy, done, div0, ovf;

  always #5 clk = ~clk;

  booth_divider dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .DIVIDEND  (dividend),
    .DIVISOR   (divisor),
    .QUOTIENT  (quotient),
    .REMAINDER (remainder),
    .BUSY      (busy),
    .DONE      (done),
    .DIV0      (div0),
    .OVF       (ovf)
  );

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       d0;
    logic       ov;
    int         done_cyc;
    int         busy_cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   ncyc   = 0;
  int   busy_run = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: sample half a cycle away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        busy_run = 0;
      end else begin
        if (busy) busy_run++;
        if (done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got DONE=1 at cycle %0d expected none", ncyc);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("div0", {7'd0, div0}, {7'd0, e.d0});
            chk("ovf", {7'd0, ovf}, {7'd0, e.ov});
            chk("busy_with_done", {7'd0, busy}, 8'd0);
            chk_int("done_cycle", ncyc, e.done_cyc);
            chk_int("busy_cycles", busy_run, e.busy_cnt);
            $display("txn q=%h r=%h div0=%b ovf=%b cyc=%0d busy=%0d",
                     quotient, remainder, div0, ovf, ncyc, busy_run);
          end
          busy_run = 0;
        end
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic ed, input logic eo, input bit push,
                       output int n);
    exp_t e;
    @(negedge clk);
    #1;
    n        = ncyc;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (push) begin
      e.q        = eq;
      e.r        = er;
      e.d0       = ed;
      e.ov       = eo;
      e.done_cyc = n + ((b == 8'd0) ? 1 : 10);
      e.busy_cnt = (b == 8'd0) ? 0 : 9;
      sb.push_back(e);
    end
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait for the scoreboard to drain, then one more cycle so FIN -> IDLE.
  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] a, b, q, r;
    logic       d0, ov;
  } vec_t;

  vec_t vecs[10] = '{
    '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0},
    '{8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0},  // -100 / 7
    '{8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0},  // 100 / -7
    '{8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0},  // -100 / -7
    '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1},  // -128 / -1
    '{8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0},  // -128 / 1
    '{8'd127, 8'd127, 8'h01, 8'h00, 1'b0, 1'b0},
    '{8'd5,   8'd0,   8'hFF, 8'h05, 1'b1, 1'b0},
    '{8'd6,   8'd3,   8'h02, 8'h00, 1'b0, 1'b0},
    '{8'd13,  8'd128 - 8'd128 + 8'd2, 8'h06, 8'h01, 1'b0, 1'b0}
  };

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", quotient, 8'h00);
    chk("rst_remainder", remainder, 8'h00);
    chk("rst_flags", {4'd0, busy, done, div0, ovf}, 8'h00);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].d0, vecs[i].ov, 1'b1, n);
      wait_idle();
      if (i == 7) chk("div0_held", {7'd0, div0}, 8'd1);
    end

    // START during ITER (E3) and during FIN (E10) must both be ignored.
    issue(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b1, n);
    @(negedge clk);
    @(negedge clk);
    #1;
    start = 1'b1; dividend = 8'd3; divisor = 8'd1;
    @(negedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 20 && ncyc < n + 10; k++) @(negedge clk);
    #1;
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk_int("ignored_start_pending", sb.size(), 0);
    chk("held_quotient", quotient, 8'h0E);
    chk("held_remainder", remainder, 8'h02);
    #1;

    // Reset at E4 of a running division aborts without a DONE pulse.
    issue(8'd50, 8'd3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, n);
    for (int k = 0; k < 10 && ncyc < n + 4; k++) @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_quotient", quotient, 8'h00);
    chk("abort_remainder", remainder, 8'h00);
    chk("abort_flags", {4'd0, busy, done, div0, ovf}, 8'h00);
    #1;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    issue(8'd9, 8'd4, 8'h02, 8'h01, 1'b0, 1'b0, 1'b1, n);
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/booth_divider.md
# booth_divider

Sequential signed 8-bit divider, the inverse companion of the radix-4 Booth multiplier datapath: takes a dividend and divisor, runs radix-2 non-restoring iterations on operand magnitudes with a 10-bit add/sub unit, then applies signs. It sits beside the multiplier in the arithmetic unit and shares the same START/DONE style of operand handoff. Division is truncating: the quotient rounds toward zero, and the remainder takes the sign of the dividend.

## Interface
- N, 8, operand/result width; only 8 is verified.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request; sampled only in IDLE.
- DIVIDEND  in  8  signed two's-complement; captured on the START edge.
- DIVISOR  in  8  signed two's-complement; captured on the START edge.
- QUOTIENT  out  8  signed result; held until the next accepted START.
- REMAINDER  out  8  signed result; held until the next accepted START.
- BUSY  out  1  high from the cycle after an accepted START until DONE is high.
- DONE  out  1  one-cycle pulse; results are valid while it is high.
- DIV0  out  1  divisor was zero; valid with DONE, held with results.
- OVF  out  1  -128 / -1 overflow; valid with DONE, held with results.

## Operation
- States: IDLE, ITER, CORR, FIN.
- IDLE + START:
  - Capture sign bits and magnitudes |DIVIDEND| and |DIVISOR|; |-128| = 128 fits 8-bit unsigned.
  - Clear the 10-bit partial remainder R; load quotient Q = |DIVIDEND|; set count = 8.
  - DIVISOR == 0: go straight to FIN with QUOTIENT = 8'hFF, REMAINDER = DIVIDEND, DIV0 = 1.
  - Otherwise go to ITER.
- ITER, one step per cycle:
  - Shift {R,Q} left by 1.
  - If R >= 0 then R = R - D, else R = R + D (D zero-extended to 10 bits).
  - Q[0] = ~R_new[9]; decrement count; at count 1 go to CORR.
- Width rule: R stays in [-D, D) with D ≤ 128, so the shifted R is within ±256. 10-bit signed is sufficient, with no truncation.
- CORR: if R < 0 then R = R + D; go to FIN.
- FIN:
  - Register QUOTIENT = (sign_a ^ sign_b) ? -Q : Q.
  - Register REMAINDER = sign_a ? -R[7:0] : R[7:0].
  - -128 / -1 is the only overflow case: QUOTIENT = 8'h80, REMAINDER = 0, OVF = 1.
  - DONE = 1 for this cycle; next state is IDLE.
- START outside IDLE is ignored. A START in the FIN cycle is ignored; it must be reasserted in IDLE.
- DIV0 and OVF clear on the next accepted START.

## Timing
- Reset values: all outputs 0; state IDLE; internal registers 0.
- Reset mid-operation: abort and return to IDLE with all outputs 0 on the next edge. No DONE pulse is produced.
- Normal latency, with START sampled at edge E0:
  - ITER is active for edges E1..E8; CORR at E9.
  - FIN (DONE high, outputs valid) in the cycle after E9.
  - IDLE after E10; earliest next accept is edge E11.
- Divide-by-zero latency: FIN is entered at E0, so DONE is high in the cycle after E0.
- BUSY is high in the ITER and CORR cycles and low in IDLE and FIN. BUSY and DONE are never both high.
- QUOTIENT and REMAINDER change only on entry to FIN (or on reset).

## Structure
- Shared package div_pkg holds:
  - the state enum {IDLE, ITER, CORR, FIN};
  - the widths N = 8 and RW = 10;
  - the iteration count constant 8;
  - the constants QUO_DIV0 = 8'hFF and QUO_OVF = 8'h80.
- One sub-module: div_addsub, a 10-bit combinational add/subtract selected by SUB. It is used by both ITER and CORR.
- The FSM, counter and sign fix-up stay in booth_divider.

## Test plan
- 100 / 7 -> QUOTIENT = 8'h0E, REMAINDER = 8'h02; DONE in the cycle after E9; BUSY high for exactly 9 cycles.
- -100 / 7 -> 8'hF2 / 8'hFE. 100 / -7 -> 8'hF2 / 8'h02. -100 / -7 -> 8'h0E / 8'hFE.
- -128 / -1 -> QUOTIENT = 8'h80, REMAINDER = 0, OVF = 1. -128 / 1 -> 8'h80 / 0 with OVF = 0. 127 / 127 -> 1 / 0.
- 5 / 0 -> DONE in the cycle after E0, DIV0 = 1, QUOTIENT = 8'hFF, REMAINDER = 8'h05. Next START with 6 / 3 -> DIV0 cleared, result 2 / 0.
- START pulsed with new operands at E3 and in the FIN cycle -> both ignored; first result unchanged; no second DONE.
- RST asserted at E4 of a running division -> all outputs 0 and IDLE next cycle, no DONE. A fresh 9 / 4 then yields 2 / 1 with normal latency.
